// File: rtl/sdram_ring_ptrs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sdram_ring_ptrs
// Brief    : {bank,row} write/read pointer manager for the SDRAM stream ring
//            with exact level, full/empty/watermark flags and sticky errors.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module sdram_ring_ptrs #(
  parameter int ROW_W      = 13,
  parameter int BANK_W     = 2,
  parameter int AFULL_LVL  = 2**(ROW_W+BANK_W)-4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clr,
  input  logic                    wr_req,
  input  logic                    rd_req,
  input  logic                    err_clr,
  output logic [ROW_W-1:0]        wr_row,
  output logic [BANK_W-1:0]       wr_bank,
  output logic [ROW_W-1:0]        rd_row,
  output logic [BANK_W-1:0]       rd_bank,
  output logic [ROW_W+BANK_W:0]   level,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW    = ROW_W + BANK_W;
  localparam int DEPTH = 2**PW;

  localparam logic [PW:0] c_AFULL_LVL  = (PW+1)'(AFULL_LVL);
  localparam logic [PW:0] c_AEMPTY_LVL = (PW+1)'(AEMPTY_LVL);
  localparam logic [PW:0] c_ONE        = (PW+1)'(1);

  if (AFULL_LVL > DEPTH || AEMPTY_LVL >= DEPTH) begin : g_bad_params
    $error("sdram_ring_ptrs: watermark levels out of range for DEPTH");
  end

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0] level_q,  level_d;
  logic        empty_q,  empty_d;
  logic        full_q,   full_d;
  logic        afull_q,  afull_d;
  logic        aempty_q, aempty_d;
  logic        ovf_q,    ovf_d;
  logic        udf_q,    udf_d;

  logic        w_rd_ok;
  logic        w_wr_ok;

  // Acceptance uses pre-edge flags; no empty bypass, full accepts only paired reads.
  assign w_rd_ok = rd_req & ~empty_q;
  assign w_wr_ok = wr_req & (~full_q | w_rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = (ovf_q & ~err_clr) | (wr_req & ~w_wr_ok);
    udf_d    = (udf_q & ~err_clr) | (rd_req & ~w_rd_ok);

    if (w_wr_ok) wr_ptr_d = wr_ptr_q + c_ONE;
    if (w_rd_ok) rd_ptr_d = rd_ptr_q + c_ONE;

    case ({w_wr_ok, w_rd_ok})
      2'b10:   level_d = level_q + c_ONE;
      2'b01:   level_d = level_q - c_ONE;
      default: level_d = level_q;
    endcase

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]) & (wr_ptr_d[PW] != rd_ptr_d[PW]);
    afull_d  = (level_d >= c_AFULL_LVL);
    aempty_d = (level_d <= c_AEMPTY_LVL);
  end

  // Reset leaves almost_full low regardless of AFULL_LVL.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign {wr_bank, wr_row} = wr_ptr_q[PW-1:0];
  assign {rd_bank, rd_row} = rd_ptr_q[PW-1:0];
  assign level             = level_q;
  assign empty             = empty_q;
  assign full              = full_q;
  assign almost_full       = afull_q;
  assign almost_empty      = aempty_q;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_ring_ptrs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_sdram_ring_ptrs
// Brief    : directed self-checking bench for sdram_ring_ptrs (DEPTH=16).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_sdram_ring_ptrs;

  localparam int c_ROW_W  = 3;
  localparam int c_BANK_W = 1;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clr = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] wr_row;
  logic [0:0] wr_bank;
  logic [2:0] rd_row;
  logic [0:0] rd_bank;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_pass   = 0;

  sdram_ring_ptrs #(
    .ROW_W      (c_ROW_W),
    .BANK_W     (c_BANK_W),
    .AFULL_LVL  (12),
    .AEMPTY_LVL (4)
  ) u_dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr          (clr),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .err_clr      (err_clr),
    .wr_row       (wr_row),
    .wr_bank      (wr_bank),
    .rd_row       (rd_row),
    .rd_bank      (rd_bank),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // One clock with the given strobes; outputs are stable 1 ns after the edge.
  task automatic cyc(input logic w, input logic r, input logic c, input logic e);
    wr_req = w; rd_req = r; clr = c; err_clr = e;
    @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"},  level, 0);
    check({tag, "_wptr"},   {wr_bank, wr_row}, 0);
    check({tag, "_rptr"},   {rd_bank, rd_row}, 0);
    check({tag, "_empty"},  empty, 1);
    check({tag, "_full"},   full, 0);
    check({tag, "_aempty"}, almost_empty, 1);
    check({tag, "_afull"},  almost_full, 0);
    check({tag, "_ovf"},    overflow, 0);
    check({tag, "_udf"},    underflow, 0);
  endtask

  task automatic check_inv(input string tag);
    int unsigned diff;
    diff = (int'({wr_bank, wr_row}) - int'({rd_bank, rd_row})) & 15;
    check({tag, "_inv_low"}, level & 5'd15, diff);
    check({tag, "_inv_rng"}, (level <= 5'd16) ? 1 : 0, 1);
  endtask

  initial begin
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 4)  check("p4_aempty", almost_empty, 1);
      if (i == 5)  begin check("p5_level", level, 5); check("p5_aempty", almost_empty, 0); end
      if (i == 11) check("p11_afull", almost_full, 0);
      if (i == 12) check("p12_afull", almost_full, 1);
      if (i == 15) check("p15_full", full, 0);
    end
    check("p16_full",  full, 1);
    check("p16_level", level, 16);
    check("p16_wbank", wr_bank, 0);
    check("p16_wrow",  wr_row, 0);
    check("p16_ovf",   overflow, 0);
    check("p16_empty", empty, 0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("ovw_level", level, 16);
    check("ovw_wptr",  {wr_bank, wr_row}, 0);
    check("ovw_ovf",   overflow, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_sticky", overflow, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("errclr_ovf", overflow, 0);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("fullwr_wptr",  {wr_bank, wr_row}, 1);
    check("fullwr_rptr",  {rd_bank, rd_row}, 1);
    check("fullwr_level", level, 16);
    check("fullwr_full",  full, 1);
    check("fullwr_ovf",   overflow, 0);

    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("drain_level", level, 0);
    check("drain_empty", empty, 1);
    check("drain_rptr",  {rd_bank, rd_row}, 1);
    check("drain_udf",   underflow, 0);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("emptywr_level", level, 1);
    check("emptywr_rptr",  {rd_bank, rd_row}, 1);
    check("emptywr_wptr",  {wr_bank, wr_row}, 2);
    check("emptywr_udf",   underflow, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("rd1_level", level, 0);
    check("rd1_udf",   underflow, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("setwins_udf", underflow, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("errclr_udf", underflow, 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_reset_vals("clr0");
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_inv("wrap_w");
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check_inv("wrap_r");
    end
    check("wrap_wbank", wr_bank, 0);
    check("wrap_wrow",  wr_row, 4);
    check("wrap_rrow",  rd_row, 4);
    check("wrap_empty", empty, 1);
    check("wrap_udf",   underflow, 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_arst_level", level, 7);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("preclr_level", level, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("clrwr_level", level, 0);
    check("clrwr_empty", empty, 1);
    check("clrwr_wptr",  {wr_bank, wr_row}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
